// File: rtl/hamming_tx_scheduler.sv
// hamming_tx_scheduler
//   Shares one combinational Hamming(7,4) encoder among NREQ nibble sources.
//   A round-robin arbiter accepts one nibble at a time, presents it to the
//   encoder, captures the codeword and shifts it out MSB-first with a frame
//   strobe, followed by GAP idle cycles.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high
//   req_valid     per-requester "nibble pending"
//   req_msg       nibble of requester i at [4i+3:4i]
//   req_ready     one-hot accept pulse, only in IDLE
//   enc_message   nibble presented to the encoder (holds the last accepted one)
//   enc_codeword  codeword returned by the encoder, sampled at the end of LOAD
//   tx_bit        serial data, codeword bit 6 first, 0 when tx_valid is low
//   tx_valid      tx_bit is meaningful
//   tx_start      first bit of a frame
//   tx_chan       requester that owns the current/last frame
//   busy          any state other than IDLE
//
// State  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a request; grant and latch happen here
// LOAD   | encoder sees msg_reg; codeword captured at the end
// SHIFT  | seven data bits on tx_bit, MSB first
// GAP    | GAP quiet cycles before the next accept

module hamming_tx_scheduler #(
    parameter int NREQ = 4,
    parameter int GAP  = 1,
    parameter int CHW  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_msg,
    output logic [NREQ-1:0]     req_ready,
    output logic [3:0]          enc_message,
    input  logic [6:0]          enc_codeword,
    output logic                tx_bit,
    output logic                tx_valid,
    output logic                tx_start,
    output logic [CHW-1:0]      tx_chan,
    output logic                busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]     state;
    logic [3:0]     msg_reg;
    logic [6:0]     sreg;
    logic [2:0]     bit_cnt;
    logic [3:0]     gap_cnt;
    logic [CHW-1:0] last_grant;

    logic           gnt_any;
    logic [CHW-1:0] gnt_idx;
    logic [3:0]     gnt_msg;
    logic           hi_any;
    logic [CHW-1:0] hi_idx;
    logic [CHW-1:0] lo_idx;

    // Round-robin: the lowest valid index above last_grant wins; if there is
    // none, wrap around to the lowest valid index overall. The descending
    // loop lets the smallest index overwrite larger ones.
    always_comb begin
        gnt_any = 1'b0;
        hi_any  = 1'b0;
        hi_idx  = '0;
        lo_idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_any = 1'b1;
                lo_idx  = CHW'(i);
                if (i > int'(last_grant)) begin
                    hi_any = 1'b1;
                    hi_idx = CHW'(i);
                end
            end
        end
        gnt_idx = hi_any ? hi_idx : lo_idx;
    end

    always_comb begin
        gnt_msg = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == CHW'(i)) begin
                gnt_msg = req_msg[4*i +: 4];
            end
        end
    end

    // Gated by reset so that every output reads 0 while reset is held,
    // even though req_ready is combinational on req_valid.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (state == S_IDLE) && !reset && gnt_any && (gnt_idx == CHW'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            msg_reg    <= 4'd0;
            sreg       <= 7'd0;
            bit_cnt    <= 3'd0;
            gap_cnt    <= 4'd0;
            last_grant <= CHW'(NREQ - 1);
            tx_chan    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        msg_reg    <= gnt_msg;
                        last_grant <= gnt_idx;
                        tx_chan    <= gnt_idx;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sreg    <= enc_codeword;
                    bit_cnt <= 3'd0;
                    state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    sreg <= {sreg[5:0], 1'b0};
                    if (bit_cnt == 3'd6) begin
                        if (GAP > 0) begin
                            gap_cnt <= 4'(GAP - 1);
                            state   <= S_GAP;
                        end else begin
                            state   <= S_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign enc_message = msg_reg;
    assign tx_valid    = (state == S_SHIFT);
    assign tx_bit      = tx_valid & sreg[6];
    assign tx_start    = tx_valid && (bit_cnt == 3'd0);
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// tb_hamming_tx_scheduler
//   Directed bench for hamming_tx_scheduler. Two instances share stimulus:
//   u_dut_a with GAP=1 and u_dut_b with GAP=0; `sel` picks which one is
//   observed. The encoder is modelled as the cyclic Hamming(7,4) code with
//   generator x^3+x+1 (codeword = message * 1011, carry-less).

module tb_hamming_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_msg;
    logic        sel;

    logic [3:0] rdy_a, rdy_b, msg_a, msg_b;
    logic [6:0] cw_a, cw_b;
    logic       bit_a, bit_b, val_a, val_b, st_a, st_b, busy_a, busy_b;
    logic [1:0] chan_a, chan_b;

    logic [3:0] obs_ready, obs_msg;
    logic       obs_bit, obs_valid, obs_start, obs_busy;
    logic [1:0] obs_chan;

    int passed = 0;
    int total  = 0;
    int cyc_n  = 0;
    int t0;

    function automatic logic [6:0] enc(input logic [3:0] m);
        logic [6:0] w;
        w = {3'b000, m};
        return (w << 3) ^ (w << 1) ^ w;
    endfunction

    assign cw_a = enc(msg_a);
    assign cw_b = enc(msg_b);

    hamming_tx_scheduler #(.NREQ(4), .GAP(1), .CHW(2)) u_dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_msg(req_msg),
        .req_ready(rdy_a), .enc_message(msg_a), .enc_codeword(cw_a),
        .tx_bit(bit_a), .tx_valid(val_a), .tx_start(st_a), .tx_chan(chan_a),
        .busy(busy_a)
    );

    hamming_tx_scheduler #(.NREQ(4), .GAP(0), .CHW(2)) u_dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_msg(req_msg),
        .req_ready(rdy_b), .enc_message(msg_b), .enc_codeword(cw_b),
        .tx_bit(bit_b), .tx_valid(val_b), .tx_start(st_b), .tx_chan(chan_b),
        .busy(busy_b)
    );

    assign obs_ready = sel ? rdy_b  : rdy_a;
    assign obs_msg   = sel ? msg_b  : msg_a;
    assign obs_bit   = sel ? bit_b  : bit_a;
    assign obs_valid = sel ? val_b  : val_a;
    assign obs_start = sel ? st_b   : st_a;
    assign obs_busy  = sel ? busy_b : busy_a;
    assign obs_chan  = sel ? chan_b : chan_a;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Entered at mid-cycle of the accept cycle; leaves at mid-cycle of the
    // last checked bit. `hold` is the req_valid pattern from LOAD onwards.
    task automatic frame(input string tag, input logic [6:0] cw, input int chan,
                         input logic [3:0] hold, input int nbits, input logic [3:0] m);
        nxt();
        req_valid = hold;
        mid();
        chk({tag, ".load_valid"}, obs_valid, 0);
        chk({tag, ".load_busy"},  obs_busy,  1);
        chk({tag, ".load_ready"}, obs_ready, 0);
        chk({tag, ".load_msg"},   obs_msg,   m);
        chk({tag, ".chan"},       obs_chan,  chan);
        for (int i = 0; i < nbits; i++) begin
            nxt();
            mid();
            chk($sformatf("%s.valid%0d", tag, i), obs_valid, 1);
            chk($sformatf("%s.bit%0d",   tag, i), obs_bit,   cw[6-i]);
            chk($sformatf("%s.start%0d", tag, i), obs_start, (i == 0) ? 1 : 0);
            chk($sformatf("%s.ready%0d", tag, i), obs_ready, 0);
        end
    endtask

    // GAP=1 instance: one quiet cycle, then IDLE.
    task automatic gap_then_idle(input string tag, input logic [3:0] exp_ready);
        nxt();
        mid();
        chk({tag, ".gap_valid"}, obs_valid, 0);
        chk({tag, ".gap_bit"},   obs_bit,   0);
        chk({tag, ".gap_busy"},  obs_busy,  1);
        chk({tag, ".gap_ready"}, obs_ready, 0);
        nxt();
        mid();
        chk({tag, ".idle_busy"},  obs_busy,  0);
        chk({tag, ".idle_ready"}, obs_ready, exp_ready);
    endtask

    logic [6:0] cw_tab [4];

    initial begin
        cw_tab[0] = 7'b0001011;
        cw_tab[1] = 7'b0010110;
        cw_tab[2] = 7'b0101100;
        cw_tab[3] = 7'b1011000;

        sel       = 1'b0;
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_msg   = 16'h0000;
        repeat (2) @(posedge clk);
        mid();
        chk("rst.ready", obs_ready, 0);
        chk("rst.busy",  obs_busy,  0);
        chk("rst.valid", obs_valid, 0);
        chk("rst.start", obs_start, 0);
        chk("rst.bit",   obs_bit,   0);
        chk("rst.chan",  obs_chan,  0);
        chk("rst.msg",   obs_msg,   0);
        nxt();
        reset     = 1'b0;
        req_valid = 4'b0000;

        // single request, GAP=1
        nxt();
        req_valid = 4'b0001;
        req_msg   = 16'h000B;
        mid();
        chk("t1.ready", obs_ready, 4'b0001);
        chk("t1.busy",  obs_busy,  0);
        frame("t1", 7'b1000101, 0, 4'b0000, 7, 4'hB);
        gap_then_idle("t1", 4'b0000);

        // back-to-back on requester 2
        nxt();
        req_valid = 4'b0100;
        req_msg   = 16'h0100;
        mid();
        chk("t2.ready_a", obs_ready, 4'b0100);
        t0 = cyc_n;
        frame("t2a", 7'b0001011, 2, 4'b0100, 7, 4'h1);
        req_msg = 16'h0F00;
        gap_then_idle("t2a", 4'b0100);
        chk("t2.period", cyc_n - t0, 10);
        frame("t2b", 7'b1101001, 2, 4'b0000, 7, 4'hF);
        gap_then_idle("t2b", 4'b0000);

        // requester 1 arrives while requester 0 is shifting
        nxt();
        req_valid = 4'b0001;
        req_msg   = 16'h0096;
        mid();
        chk("t4.ready0", obs_ready, 4'b0001);
        frame("t4a", 7'b0111010, 0, 4'b0010, 7, 4'h6);
        gap_then_idle("t4a", 4'b0010);
        frame("t4b", 7'b1010011, 1, 4'b0010, 7, 4'h9);
        req_valid = 4'b0000;
        gap_then_idle("t4b", 4'b0000);

        // reset in the middle of a frame
        nxt();
        req_valid = 4'b0100;
        req_msg   = 16'h0100;
        mid();
        chk("t5.ready2", obs_ready, 4'b0100);
        frame("t5a", 7'b0001011, 2, 4'b0000, 3, 4'h1);
        nxt();
        reset = 1'b1;
        #1;
        chk("t5.abort_valid", obs_valid, 0);
        chk("t5.abort_busy",  obs_busy,  0);
        chk("t5.abort_bit",   obs_bit,   0);
        chk("t5.abort_chan",  obs_chan,  0);
        chk("t5.abort_msg",   obs_msg,   0);
        mid();
        req_valid = 4'b1001;
        req_msg   = 16'h8007;
        #1;
        chk("t5.rst_ready", obs_ready, 0);
        nxt();
        nxt();
        reset = 1'b0;
        mid();
        chk("t5.first_grant", obs_ready, 4'b0001);
        frame("t5b", 7'b0110001, 0, 4'b0000, 7, 4'h7);
        gap_then_idle("t5b", 4'b0000);

        // all four valid from a fresh reset: rotation 0,1,2,3,0
        nxt();
        reset = 1'b1;
        nxt();
        reset     = 1'b0;
        req_valid = 4'b1111;
        req_msg   = 16'h8421;
        mid();
        chk("t3.ready_first", obs_ready, 4'b0001);
        for (int g = 0; g < 5; g++) begin
            frame($sformatf("t3.f%0d", g), cw_tab[g % 4], g % 4,
                  (g == 4) ? 4'h0 : 4'hF, 7, req_msg[4*(g%4) +: 4]);
            gap_then_idle($sformatf("t3.f%0d", g),
                          (g == 4) ? 4'b0000 : 4'(1 << ((g + 1) % 4)));
        end

        // GAP=0 instance, requester 3 held valid with a zero nibble
        sel = 1'b1;
        nxt();
        reset = 1'b1;
        nxt();
        reset     = 1'b0;
        req_valid = 4'b1000;
        req_msg   = 16'h0000;
        mid();
        chk("t6.ready_first", obs_ready, 4'b1000);
        t0 = cyc_n;
        for (int f = 0; f < 3; f++) begin
            frame($sformatf("t6.f%0d", f), 7'b0000000, 3, 4'b1000, 7, 4'h0);
            nxt();
            mid();
            chk($sformatf("t6.f%0d.idle_valid", f), obs_valid, 0);
            chk($sformatf("t6.f%0d.idle_busy", f),  obs_busy,  0);
            chk($sformatf("t6.f%0d.ready", f),      obs_ready, 4'b1000);
            chk($sformatf("t6.f%0d.period", f),     cyc_n - t0, 9);
            t0 = cyc_n;
        end
        req_valid = 4'b0000;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
